// File: rtl/scroll_display_ctrl.sv
// Scrolling-message engine for the 7-segment bank.
// Holds a writable buffer of segment codes and shows a NUM_DIGITS-wide window
// onto it. The window rotates on a programmable period or on manual step pulses.
module scroll_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_DEPTH  = 16,
  parameter int SEG_W      = 7,
  parameter int DIV_W      = 26,
  parameter int CNT_W      = 10,
  localparam int AW        = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [SEG_W-1:0]            wr_data,
  input  logic [AW:0]                 msg_len,
  input  logic [DIV_W-1:0]            period,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        dir,
  input  logic                        manual,
  input  logic                        step,
  output logic [NUM_DIGITS*SEG_W-1:0] display,
  output logic [CNT_W-1:0]            step_count,
  output logic                        running,
  output logic                        wrap
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(MSG_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                        state;
  logic [SEG_W-1:0]              msg_buf [MSG_DEPTH];
  logic [AW-1:0]                 offset;
  logic [AW:0]                   len;
  logic [DIV_W-1:0]              per;
  logic [DIV_W-1:0]              tick;
  logic [NUM_DIGITS*SEG_W-1:0]   window;
  logic                          step_ev;
  logic [AW-1:0]                 next_off;
  logic [AW:0]                   last;

  // Buffer slot shown on digit k; len is never zero once out of reset.
  function automatic logic [AW-1:0] win_index(input logic [AW-1:0] off,
                                              input logic [AW:0] l,
                                              input int k);
    logic [31:0] sum;
    sum = 32'(off) + 32'(NUM_DIGITS - 1 - k);
    return AW'(sum % 32'(l));
  endfunction

  // Gather the visible window; indices wrap modulo the message length.
  always_comb begin
    window = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      window[k*SEG_W +: SEG_W] = msg_buf[win_index(offset, len, k)];
    end
  end

  // Decide whether this cycle advances the window and where it lands.
  always_comb begin
    step_ev  = 1'b0;
    last     = len - (AW+1)'(1);
    next_off = offset;
    if (state == RUN) begin
      step_ev = manual ? step : (tick == per - DIV_W'(1));
    end
    if (dir) begin
      next_off = (offset == '0) ? last[AW-1:0] : offset - AW'(1);
    end else begin
      next_off = ({1'b0, offset} == last) ? '0 : offset + AW'(1);
    end
  end

  // Control FSM, message buffer and registered outputs; stop beats start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      running    <= 1'b0;
      offset     <= '0;
      len        <= DEPTH_L;
      per        <= DIV_W'(1);
      tick       <= '0;
      step_count <= '0;
      wrap       <= 1'b0;
      display    <= '1;
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg_buf[i] <= '1;
      end
    end else begin
      display <= window;
      wrap    <= 1'b0;
      if (state == IDLE && wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
        msg_buf[wr_addr] <= wr_data;
      end
      if (stop) begin
        state   <= IDLE;
        running <= 1'b0;
        tick    <= '0;
      end else if (start && msg_len != '0) begin
        state      <= RUN;
        running    <= 1'b1;
        len        <= (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
        per        <= (period == '0) ? DIV_W'(1) : period;
        offset     <= '0;
        tick       <= '0;
        step_count <= '0;
      end else if (state == RUN) begin
        if (manual || step_ev) begin
          tick <= '0;
        end else begin
          tick <= tick + DIV_W'(1);
        end
        if (step_ev) begin
          offset     <= next_off;
          step_count <= step_count + CNT_W'(1);
          wrap       <= (next_off == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Self-checking bench for scroll_display_ctrl: directed scenarios followed by
// random traffic, all compared each cycle against a behavioural model.
module tb_scroll_display_ctrl;

  localparam int NUM_DIGITS = 6;
  localparam int MSG_DEPTH  = 16;
  localparam int SEG_W      = 7;
  localparam int DIV_W      = 26;
  localparam int CNT_W      = 10;
  localparam int AW         = $clog2(MSG_DEPTH);
  localparam int DISP_W     = NUM_DIGITS * SEG_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [SEG_W-1:0]  wr_data;
  logic [AW:0]       msg_len;
  logic [DIV_W-1:0]  period;
  logic              start;
  logic              stop;
  logic              dir;
  logic              manual;
  logic              step;
  logic [DISP_W-1:0] display;
  logic [CNT_W-1:0]  step_count;
  logic              running;
  logic              wrap;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int              mbuf [MSG_DEPTH];
  int              m_off;
  int              m_len = MSG_DEPTH;
  int              m_per;
  int              m_tick;
  int              m_cnt;
  bit              m_run;
  bit              m_wrap;
  logic [DISP_W-1:0] m_disp;

  // Free-running clock
  always #5 clock = ~clock;

  scroll_display_ctrl #(
    .NUM_DIGITS(NUM_DIGITS), .MSG_DEPTH(MSG_DEPTH), .SEG_W(SEG_W),
    .DIV_W(DIV_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .msg_len(msg_len), .period(period), .start(start),
    .stop(stop), .dir(dir), .manual(manual), .step(step),
    .display(display), .step_count(step_count), .running(running), .wrap(wrap)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    logic [DISP_W-1:0] nd;
    bit ev;
    nd = '1;
    ev = 1'b0;
    m_wrap = 1'b0;
    if (reset) begin
      for (int i = 0; i < MSG_DEPTH; i++) mbuf[i] = (1 << SEG_W) - 1;
      m_off = 0; m_len = MSG_DEPTH; m_per = 1; m_tick = 0; m_cnt = 0; m_run = 1'b0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++)
        nd[k*SEG_W +: SEG_W] = SEG_W'(mbuf[(m_off + NUM_DIGITS - 1 - k) % m_len]);
      if (!m_run && wr_en && int'(wr_addr) < MSG_DEPTH) mbuf[wr_addr] = int'(wr_data);
      if (stop) begin
        m_run = 1'b0; m_tick = 0;
      end else if (start && msg_len != 0) begin
        m_len  = (int'(msg_len) > MSG_DEPTH) ? MSG_DEPTH : int'(msg_len);
        m_per  = (period == 0) ? 1 : int'(period);
        m_off  = 0; m_tick = 0; m_cnt = 0; m_run = 1'b1;
      end else if (m_run) begin
        if (manual) begin
          m_tick = 0;
          ev = step;
        end else begin
          m_tick++;
          if (m_tick == m_per) begin
            ev = 1'b1;
            m_tick = 0;
          end
        end
        if (ev) begin
          m_off  = dir ? (m_off + m_len - 1) % m_len : (m_off + 1) % m_len;
          m_cnt  = (m_cnt + 1) % (1 << CNT_W);
          m_wrap = (m_off == 0);
        end
      end
    end
    m_disp = nd;
  endtask

  // Run n clock cycles with the current inputs, checking outputs on each negedge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clock);
      modelStep();
      @(negedge clock);
      checkOutput("display",    64'(display),    64'(m_disp));
      checkOutput("step_count", 64'(step_count), 64'(m_cnt));
      checkOutput("running",    64'(running),    64'(m_run));
      checkOutput("wrap",       64'(wrap),       64'(m_wrap));
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
    period = '0; start = 1'b0; stop = 1'b0; dir = 1'b0; manual = 1'b0; step = 1'b0;
    @(negedge clock);
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(3);
    checkOutput("reset_display", 64'(display), 64'({DISP_W{1'b1}}));
    checkOutput("reset_running", 64'(running), 64'(0));

    // Load codes A..H and scroll left with period 4
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = SEG_W'(7'h10 + i);
      applyStimulus(1);
    end
    wr_en = 1'b0;
    msg_len = 5'd8; period = 26'd4; dir = 1'b0; start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("run_after_start", 64'(running), 64'(1));
    applyStimulus(5);
    checkOutput("left_shows_B", 64'(display[DISP_W-1 -: SEG_W]), 64'(7'h11));
    applyStimulus(27);
    checkOutput("left_wrap8", 64'(wrap), 64'(1));
    checkOutput("left_count8", 64'(step_count), 64'(8));

    // Scroll right every cycle
    dir = 1'b1; period = 26'd1; start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(2);
    checkOutput("right_shows_H", 64'(display[DISP_W-1 -: SEG_W]), 64'(7'h17));
    applyStimulus(6);
    checkOutput("right_wrap8", 64'(wrap), 64'(1));

    // Manual stepping, then step pulses while idle
    manual = 1'b1; dir = 1'b0; period = 26'd3; start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; applyStimulus(1);
      step = 1'b0; applyStimulus(9);
    end
    checkOutput("manual_count3", 64'(step_count), 64'(3));
    stop = 1'b1; applyStimulus(1); stop = 1'b0;
    step = 1'b1; applyStimulus(1); step = 1'b0;
    applyStimulus(2);
    checkOutput("idle_step_count", 64'(step_count), 64'(3));
    manual = 1'b0;

    // Writes during RUN ignored; start+stop together stops; zero length ignored
    period = 26'd2; start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    wr_en = 1'b1; wr_addr = '0; wr_data = 7'h55;
    applyStimulus(3);
    wr_en = 1'b0;
    applyStimulus(2);
    start = 1'b1; stop = 1'b1;
    applyStimulus(1);
    start = 1'b0; stop = 1'b0;
    checkOutput("start_stop_idle", 64'(running), 64'(0));
    applyStimulus(3);
    checkOutput("offset_kept", 64'(display[DISP_W-1 -: SEG_W]), 64'(7'h12));
    msg_len = '0; start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(1);
    checkOutput("zero_len_idle", 64'(running), 64'(0));

    // Length clamp: 20 becomes 16, so wrap arrives after 16 steps
    msg_len = 5'd20; period = 26'd1; start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(15);
    checkOutput("clamp_no_wrap15", 64'(wrap), 64'(0));
    applyStimulus(1);
    checkOutput("clamp_wrap16", 64'(wrap), 64'(1));

    // Reset in the middle of a run
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(5);
    checkOutput("pre_reset_count", 64'(step_count), 64'(5));
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("mid_reset_running", 64'(running), 64'(0));
    checkOutput("mid_reset_count", 64'(step_count), 64'(0));
    checkOutput("mid_reset_display", 64'(display), 64'({DISP_W{1'b1}}));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 299) == 0);
      wr_en   = ($urandom_range(0, 9) < 3);
      wr_addr = AW'($urandom);
      wr_data = SEG_W'($urandom);
      msg_len = (AW+1)'($urandom_range(0, 20));
      period  = DIV_W'($urandom_range(0, 6));
      start   = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 29) == 0);
      dir     = 1'($urandom);
      if ($urandom_range(0, 19) == 0) manual = ~manual;
      step    = ($urandom_range(0, 9) < 3);
      applyStimulus(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
